i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per SCL half-period, legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port start_req, input, 1: request a transaction; sampled only in IDLE.
REQ-005 SHALL have port rw, input, 1: 0 = write, 1 = read; latched on accept.
REQ-006 SHALL have port addr, input, 7: target address; latched on accept.
REQ-007 SHALL have port wdata, input, byte_t: write byte; latched on accept.
REQ-008 SHALL have port sda_in, input, 1: resolved SDA bus level, used for ACK and read sampling.
REQ-009 SHALL have port scl_out, output, 1: SCL drive level.
REQ-010 SHALL have port sda_out, output, 1: SDA drive level; 1 = released.
REQ-011 SHALL have port busy, output, 1: high from the cycle after accept through done.
REQ-012 SHALL have port done, output, 1: one-cycle pulse at transaction end.
REQ-013 SHALL have port ack_err, output, 1: target NACKed; valid with done, held until next accept.
REQ-014 SHALL have port rdata, output, byte_t: read byte; valid with done when rw=1, held until next read completes.

Function
REQ-015 SHALL accept start_req only when in IDLE, latching {addr, rw, wdata}, clearing ack_err, and restarting the divider; start_req while busy SHALL be ignored.
REQ-016 SHALL advance the bus phase once every CLK_DIV cycles ("tick") using a divider counter that runs only while busy.
REQ-017 SHALL implement states IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MNACK, STOP.
REQ-018 IDLE: scl_out=1, sda_out=1.
REQ-019 START: 2 half-periods: SDA=0 with SCL=1, then SCL=0 with SDA=0.
REQ-020 Each bit SHALL take 2 half-periods: SCL low with SDA updated at its start, then SCL high with SDA held stable.
REQ-021 ADDR: 8 bits {addr, rw}, MSB first.
REQ-022 ACK slots (ADDR_ACK, WACK): SDA released; sda_in sampled on the tick that raises SCL; 0 = ACK.
REQ-023 Transitions: ADDR_ACK with NACK -> STOP with ack_err=1. ADDR_ACK with ACK and rw=0 -> WDATA. ADDR_ACK with ACK and rw=1 -> RDATA.
REQ-024 WDATA: 8 bits of wdata, MSB first, then WACK. A NACK in WACK SHALL set ack_err. WACK always -> STOP.
REQ-025 RDATA: SDA released; 8 bits sampled MSB first on SCL-rising ticks into a shift register. MNACK: SDA=1 for one bit. Then -> STOP.
REQ-026 STOP: 3 half-periods: SCL=0/SDA=0, then SCL=1/SDA=0, then SCL=1/SDA=1.
REQ-027 After the final STOP half-period, SHALL pulse done for 1 cycle, drop busy in the same cycle, update rdata on reads, and enter IDLE.
REQ-028 SDA SHALL change only while SCL is low, except the START and STOP edges.
REQ-029 Transaction length: write or read = 41 half-periods; address NACK = 23 half-periods; done SHALL occur exactly that many × CLK_DIV cycles after the accept cycle.
REQ-030 Clock stretching and arbitration are not supported; sda_in SHALL affect only the ACK and read samples.

Reset
REQ-031 reset_n low SHALL immediately force IDLE with scl_out=1, sda_out=1, busy=0, done=0, ack_err=0, rdata=0, and counters at 0, including mid-transaction.
REQ-032 After reset release, the first start_req SHALL be accepted no earlier than the first rising clk edge with reset_n high.

Verification
REQ-033 Write: CLK_DIV=4, addr=0x2A, rw=0, wdata=0xA5, slave ACKs both slots -> SDA bits 0x54 then 0xA5; done at cycle 164; ack_err=0.
REQ-034 Read: addr=0x2A, rw=1, slave drives 0x3C -> address byte 0x55; master NACK bit SDA=1; rdata=0x3C with done at cycle 164.
REQ-035 Address NACK: sda_in=1 in ADDR_ACK -> STOP follows immediately; done at cycle 92; ack_err=1; no data bits driven.
REQ-036 Protocol: start_req pulsed while busy -> ignored; checker reports no SDA change while SCL=1 outside START/STOP.
REQ-037 Reset mid-ADDR: reset_n low at cycle 30 -> scl_out=1, sda_out=1, busy=0 that cycle; a new write afterwards completes normally.

Source files
------------

// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, one data byte (write or read), STOP.
// SCL half-period is CLK_DIV clk cycles; no clock stretching or arbitration.
package i2c_master_pkg;
   typedef logic [7:0] byte_t;
endpackage

module i2c_master
   import i2c_master_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       start_req,
   input  logic       rw,
   input  logic [6:0] addr,
   input  byte_t      wdata,
   input  logic       sda_in,
   output logic       scl_out,
   output logic       sda_out,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output byte_t      rdata
);

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, MNACK, STOP
   } state_t;

   state_t     state;
   logic [7:0] div;
   logic [1:0] phase;
   logic [2:0] bit_idx;
   byte_t      addr_byte;
   byte_t      wbyte;
   byte_t      rshift;
   logic       rw_lat;
   logic       tick;

   assign tick = (div == 8'(CLK_DIV - 1));

   // Bus sequencer: every output changes at the tick that opens a new half-period
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         div       <= 8'd0;
         phase     <= 2'd0;
         bit_idx   <= 3'd0;
         addr_byte <= 8'd0;
         wbyte     <= 8'd0;
         rshift    <= 8'd0;
         rw_lat    <= 1'b0;
         scl_out   <= 1'b1;
         sda_out   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         ack_err   <= 1'b0;
         rdata     <= 8'd0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            div <= tick ? 8'd0 : div + 8'd1;
         end else begin
            div <= 8'd0;
         end
         case (state)
            IDLE: begin
               if (start_req) begin
                  addr_byte <= {addr, rw};
                  rw_lat    <= rw;
                  wbyte     <= wdata;
                  ack_err   <= 1'b0;
                  busy      <= 1'b1;
                  div       <= 8'd0;
                  phase     <= 2'd0;
                  state     <= START;
                  scl_out   <= 1'b1;
                  sda_out   <= 1'b0;
               end
            end
            START: begin
               if (tick) begin
                  if (phase == 2'd0) begin
                     phase   <= 2'd1;
                     scl_out <= 1'b0;
                  end else begin
                     phase   <= 2'd0;
                     bit_idx <= 3'd7;
                     sda_out <= addr_byte[7];
                     state   <= ADDR;
                  end
               end
            end
            ADDR, WDATA, RDATA: begin
               if (tick) begin
                  if (phase == 2'd0) begin
                     phase   <= 2'd1;
                     scl_out <= 1'b1;
                     if (state == RDATA) begin
                        rshift <= {rshift[6:0], sda_in};
                     end
                  end else begin
                     phase   <= 2'd0;
                     scl_out <= 1'b0;
                     if (bit_idx != 3'd0) begin
                        bit_idx <= bit_idx - 3'd1;
                        case (state)
                           ADDR:    sda_out <= addr_byte[bit_idx - 3'd1];
                           WDATA:   sda_out <= wbyte[bit_idx - 3'd1];
                           default: sda_out <= 1'b1;
                        endcase
                     end else begin
                        sda_out <= 1'b1;
                        case (state)
                           ADDR:    state <= ADDR_ACK;
                           WDATA:   state <= WACK;
                           default: state <= MNACK;
                        endcase
                     end
                  end
               end
            end
            ADDR_ACK, WACK: begin
               if (tick) begin
                  if (phase == 2'd0) begin
                     phase   <= 2'd1;
                     scl_out <= 1'b1;
                     if (sda_in) begin
                        ack_err <= 1'b1;
                     end
                  end else begin
                     phase   <= 2'd0;
                     scl_out <= 1'b0;
                     // ack_err was cleared on accept, so here it means address NACK
                     if ((state == ADDR_ACK) && !ack_err) begin
                        bit_idx <= 3'd7;
                        if (rw_lat) begin
                           sda_out <= 1'b1;
                           state   <= RDATA;
                        end else begin
                           sda_out <= wbyte[7];
                           state   <= WDATA;
                        end
                     end else begin
                        sda_out <= 1'b0;
                        state   <= STOP;
                     end
                  end
               end
            end
            MNACK: begin
               if (tick) begin
                  if (phase == 2'd0) begin
                     phase   <= 2'd1;
                     scl_out <= 1'b1;
                  end else begin
                     phase   <= 2'd0;
                     scl_out <= 1'b0;
                     sda_out <= 1'b0;
                     state   <= STOP;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  case (phase)
                     2'd0: begin
                        phase   <= 2'd1;
                        scl_out <= 1'b1;
                     end
                     2'd1: begin
                        phase   <= 2'd2;
                        sda_out <= 1'b1;
                     end
                     default: begin
                        phase <= 2'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                        if (rw_lat && !ack_err) begin
                           rdata <= rshift;
                        end
                     end
                  endcase
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               phase   <= 2'd0;
               scl_out <= 1'b1;
               sda_out <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: expected bus waveform is built as a list of
// (SCL,SDA) half-periods from the protocol rules and compared cycle by cycle.
module tb_i2c_master;
   import i2c_master_pkg::*;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start_req;
   logic       rw;
   logic [6:0] addr;
   byte_t      wdata;
   logic       sda_in;
   logic       scl_out;
   logic       sda_out;
   logic       busy;
   logic       done;
   logic       ack_err;
   byte_t      rdata;
   logic       slave_bit;
   byte_t      exp_rdata;
   int         vectors = 0;
   int         miscompares = 0;

   // Open-drain bus: either side pulling low wins
   assign sda_in = sda_out & slave_bit;

   i2c_master #(.CLK_DIV(D)) dut (
      .clk(clk), .reset_n(reset_n), .start_req(start_req), .rw(rw), .addr(addr),
      .wdata(wdata), .sda_in(sda_in), .scl_out(scl_out), .sda_out(sda_out),
      .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
   );

   always #5 clk = ~clk;

   task automatic run_txn(input logic t_rw, input logic [6:0] t_addr, input byte_t t_wdata,
                          input logic a_nack, input logic d_nack, input byte_t sdata,
                          input int reset_at, input int busy_pulse);
      logic [1:0] wave[$];
      byte_t      ab;
      byte_t      cap_a;
      byte_t      cap_d;
      logic [1:0] prev;
      logic [1:0] cur;
      logic       exp_err;
      int         len;
      int         h;
      int         edges;
      ab = {t_addr, t_rw};
      wave = {};
      wave.push_back(2'b10);
      wave.push_back(2'b00);
      for (int i = 7; i >= 0; i--) begin
         wave.push_back({1'b0, ab[i]});
         wave.push_back({1'b1, ab[i]});
      end
      wave.push_back(2'b01);
      wave.push_back(2'b11);
      if (!a_nack) begin
         for (int i = 7; i >= 0; i--) begin
            wave.push_back({1'b0, t_rw ? 1'b1 : t_wdata[i]});
            wave.push_back({1'b1, t_rw ? 1'b1 : t_wdata[i]});
         end
         wave.push_back(2'b01);
         wave.push_back(2'b11);
      end
      wave.push_back(2'b00);
      wave.push_back(2'b10);
      wave.push_back(2'b11);
      len = wave.size();
      exp_err = a_nack | (!t_rw & d_nack);

      @(negedge clk);
      addr = t_addr; rw = t_rw; wdata = t_wdata; start_req = 1'b1; slave_bit = 1'b1;
      @(posedge clk);
      #1;
      start_req = 1'b0;
      addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);

      prev = 2'b11; edges = 0; cap_a = 8'h00; cap_d = 8'h00;
      for (int c = 0; c <= len * D; c++) begin
         @(negedge clk);
         h = c / D;
         if (c == reset_at) begin
            reset_n = 1'b0;
            #1;
            vectors++;
            if ({scl_out, sda_out, busy, done, ack_err, rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
               miscompares++;
               $display("FAIL reset_mid: scl/sda/busy/done/ack_err/rdata=%b%b%b%b%b/%h, need 11000/00",
                        scl_out, sda_out, busy, done, ack_err, rdata);
            end
            exp_rdata = 8'h00;
            slave_bit = 1'b1;
            @(negedge clk);
            reset_n = 1'b1;
            return;
         end
         start_req = (c == busy_pulse);
         cur = {scl_out, sda_out};
         if (c < len * D) begin
            vectors++;
            if ({cur, busy, done} !== {wave[h], 1'b1, 1'b0}) begin
               miscompares++;
               if (miscompares <= 20)
                  $display("FAIL wave c=%0d h=%0d: scl,sda,busy,done=%b, need %b",
                           c, h, {cur, busy, done}, {wave[h], 1'b1, 1'b0});
            end
            if (c == 0) begin
               vectors++;
               if (ack_err !== 1'b0) begin
                  miscompares++;
                  $display("FAIL ack_err_clear: ack_err=%b, need 0", ack_err);
               end
            end
            if (prev[1] && cur[1] && (prev[0] != cur[0])) edges++;
            if ((c % D == 0) && h >= 3 && h <= 17 && h[0]) cap_a = {cap_a[6:0], sda_in};
            if ((c % D == 0) && h >= 21 && h <= 35 && h[0]) cap_d = {cap_d[6:0], sda_in};
         end else begin
            vectors++;
            if ({cur, busy, done, ack_err} !== {2'b11, 1'b0, 1'b1, exp_err}) begin
               miscompares++;
               $display("FAIL done_cycle c=%0d: scl,sda,busy,done,ack_err=%b, need %b",
                        c, {cur, busy, done, ack_err}, {2'b11, 1'b0, 1'b1, exp_err});
            end
         end
         prev = cur;
         // Target behaviour for the half-period now on the bus
         if (h == 18 || h == 19) slave_bit = a_nack;
         else if (!a_nack && !t_rw && (h == 36 || h == 37)) slave_bit = d_nack;
         else if (!a_nack && t_rw && h >= 20 && h <= 35) slave_bit = sdata[7 - (h - 20) / 2];
         else slave_bit = 1'b1;
      end
      start_req = 1'b0;
      if (!a_nack && t_rw) exp_rdata = sdata;

      vectors++;
      if (edges !== 2) begin
         miscompares++;
         $display("FAIL sda_while_scl_high: %0d changes, need 2 (START and STOP)", edges);
      end
      vectors++;
      if (cap_a !== ab) begin
         miscompares++;
         $display("FAIL addr_byte: got %h, need %h", cap_a, ab);
      end
      if (!a_nack) begin
         vectors++;
         if (cap_d !== (t_rw ? sdata : t_wdata)) begin
            miscompares++;
            $display("FAIL data_byte: got %h, need %h", cap_d, t_rw ? sdata : t_wdata);
         end
      end
      @(negedge clk);
      vectors++;
      if ({busy, done, rdata} !== {1'b0, 1'b0, exp_rdata}) begin
         miscompares++;
         $display("FAIL after_done: busy,done=%b%b rdata=%h, need 00 rdata=%h",
                  busy, done, rdata, exp_rdata);
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; start_req = 1'b0; rw = 1'b0; addr = 7'h00; wdata = 8'h00;
      slave_bit = 1'b1; exp_rdata = 8'h00;
      repeat (3) @(negedge clk);
      vectors++;
      if ({scl_out, sda_out, busy, done, ack_err, rdata} !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         miscompares++;
         $display("FAIL reset: scl/sda/busy/done/ack_err/rdata=%b%b%b%b%b/%h, need 11000/00",
                  scl_out, sda_out, busy, done, ack_err, rdata);
      end
      reset_n = 1'b1;
   endtask

   task automatic test_write();
      run_txn(1'b0, 7'h2A, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1);
   endtask

   task automatic test_read();
      run_txn(1'b1, 7'h2A, 8'h00, 1'b0, 1'b0, 8'h3C, -1, -1);
   endtask

   task automatic test_nack();
      run_txn(1'b0, 7'h2A, 8'hA5, 1'b1, 1'b0, 8'h00, -1, -1);
      run_txn(1'b1, 7'h11, 8'h00, 1'b1, 1'b0, 8'hC3, -1, -1);
      run_txn(1'b0, 7'h50, 8'h0F, 1'b0, 1'b1, 8'h00, -1, -1);
   endtask

   task automatic test_busy_ignore();
      run_txn(1'b0, 7'h33, 8'h5A, 1'b0, 1'b0, 8'h00, -1, 50);
      run_txn(1'b1, 7'h0C, 8'h00, 1'b0, 1'b0, 8'h96, -1, 10);
   endtask

   task automatic test_reset_mid();
      run_txn(1'b0, 7'h2A, 8'hA5, 1'b0, 1'b0, 8'h00, 30, -1);
      run_txn(1'b0, 7'h2A, 8'hA5, 1'b0, 1'b0, 8'h00, -1, -1);
   endtask

   task automatic test_random();
      logic an;
      logic t_rw;
      for (int n = 0; n < 20; n++) begin
         an = ($urandom_range(0, 3) == 0);
         t_rw = 1'($urandom);
         run_txn(t_rw, 7'($urandom), 8'($urandom), an, ($urandom_range(0, 3) == 0),
                 8'($urandom), -1, $urandom_range(0, 3) == 0 ? $urandom_range(1, 80) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_nack();
      test_busy_ignore();
      test_reset_mid();
      test_read();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
